// File: rtl/modaddsub_pkg.sv
// Shared constants, limb type and FSM state encoding for the word-serial
// modular adder/subtractor.
package modaddsub_pkg;

  localparam int unsigned N  = 381;
  localparam int unsigned W  = 64;
  localparam int unsigned L  = (N + W - 1) / W;
  localparam int unsigned LW = L * W;
  localparam int unsigned CW = (L > 1) ? $clog2(L) : 1;

  typedef logic [W-1:0] limb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/modaddsub_if.sv
// Operand/result bundle for modaddsub_serial (start/done/out_read handshake).
// range_err exists only when MODADDSUB_RANGE_CHK_EN is defined.
interface modaddsub_if;
  import modaddsub_pkg::*;

  logic         start;
  logic         subtract;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic         out_read;
  logic [N-1:0] result;
  logic         done;
`ifdef MODADDSUB_RANGE_CHK_EN
  logic         range_err;

  modport master (
    output start, subtract, in_a, in_b, in_m, out_read,
    input  result, done, range_err
  );

  modport slave (
    input  start, subtract, in_a, in_b, in_m, out_read,
    output result, done, range_err
  );
`else
  modport master (
    output start, subtract, in_a, in_b, in_m, out_read,
    input  result, done
  );

  modport slave (
    input  start, subtract, in_a, in_b, in_m, out_read,
    output result, done
  );
`endif

endinterface

// File: rtl/modaddsub_limb.sv
// One W-bit limb of an add/subtract carry chain.
// sub=0: {cout,y} = a + b + cin.  sub=1: y = a - b - cin, cout = borrow out.
module modaddsub_limb
  import modaddsub_pkg::*;
(
  input  limb_t a,
  input  limb_t b,
  input  logic  cin,
  input  logic  sub,
  output limb_t y,
  output logic  cout
);

  logic [W:0] ext;

  // Single W+1-bit add or subtract; the top bit is carry (add) or borrow (sub).
  always_comb begin
    ext = '0;
    if (sub) begin
      ext = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
    end else begin
      ext = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end
  end

  assign y    = ext[W-1:0];
  assign cout = ext[W];

endmodule

// File: rtl/modaddsub_serial.sv
// Word-serial modular adder/subtractor: result = (a +/- b) mod m.
// One limb per cycle through two chained limb units: chain 1 forms s = a +/- b,
// chain 2 forms the corrected candidate t = s -/+ m. FIN picks s or t from the
// final carries. Optional macro MODADDSUB_RANGE_CHK_EN adds two borrow chains
// (a - m, b - m) and drives range_err.
module modaddsub_serial
  import modaddsub_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  modaddsub_if.slave   bus
);

  state_t        state, state_nx;
  logic          accept, step, finish;

  logic [LW-1:0] a_r, b_r, m_r;
  logic          sub_r;
  logic          c1, c2;
  logic [CW-1:0] cnt;
  logic [LW-1:0] s_sr, t_sr;
  logic [N-1:0]  result_r;
  logic          done_r;

  limb_t         s_limb, t_limb;
  logic          c1_nx, c2_nx;
  logic          take_t;

  // Chain 1: s limb = a limb +/- b limb with running carry/borrow c1.
  modaddsub_limb u_chain1 (
    .a    (a_r[W-1:0]),
    .b    (b_r[W-1:0]),
    .cin  (c1),
    .sub  (sub_r),
    .y    (s_limb),
    .cout (c1_nx)
  );

  // Chain 2: t limb = s limb - m (add) or s limb + m (sub).
  modaddsub_limb u_chain2 (
    .a    (s_limb),
    .b    (m_r[W-1:0]),
    .cin  (c2),
    .sub  (~sub_r),
    .y    (t_limb),
    .cout (c2_nx)
  );

  // add: a+b >= m when chain 1 overflowed or s - m did not borrow.
  // sub: a-b went negative when chain 1 borrowed, so take s + m.
  assign take_t = sub_r ? c1 : (c1 | ~c2);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and phase strobes; start coinciding with done is refused.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !done_r) begin
          accept   = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == CW'(L - 1)) begin
          state_nx = FIN;
        end
      end
      FIN: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, limb shifting, carry registers, result select and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r      <= '0;
      b_r      <= '0;
      m_r      <= '0;
      sub_r    <= 1'b0;
      c1       <= 1'b0;
      c2       <= 1'b0;
      cnt      <= '0;
      s_sr     <= '0;
      t_sr     <= '0;
      result_r <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= finish;
      if (accept) begin
        a_r   <= LW'(bus.in_a);
        b_r   <= LW'(bus.in_b);
        m_r   <= LW'(bus.in_m);
        sub_r <= bus.subtract;
        c1    <= 1'b0;
        c2    <= 1'b0;
        cnt   <= '0;
      end
      if (step) begin
        // Operands shift right so the current limb is always at [W-1:0];
        // results enter at the top so limb 0 lands at the bottom after L steps.
        a_r  <= a_r >> W;
        b_r  <= b_r >> W;
        m_r  <= m_r >> W;
        s_sr <= {s_limb, s_sr[LW-1:W]};
        t_sr <= {t_limb, t_sr[LW-1:W]};
        c1   <= c1_nx;
        c2   <= c2_nx;
        cnt  <= cnt + CW'(1);
      end
      if (finish) begin
        result_r <= take_t ? t_sr[N-1:0] : s_sr[N-1:0];
      end
    end
  end

  assign bus.result = result_r;
  assign bus.done   = done_r;

`ifdef MODADDSUB_RANGE_CHK_EN
  logic  bor_a, bor_b, bor_a_nx, bor_b_nx;
  logic  range_err_r;
  limb_t diff_a_unused, diff_b_unused;

  // a - m borrow chain; no final borrow means a >= m.
  modaddsub_limb u_rng_a (
    .a    (a_r[W-1:0]),
    .b    (m_r[W-1:0]),
    .cin  (bor_a),
    .sub  (1'b1),
    .y    (diff_a_unused),
    .cout (bor_a_nx)
  );

  // b - m borrow chain.
  modaddsub_limb u_rng_b (
    .a    (b_r[W-1:0]),
    .b    (m_r[W-1:0]),
    .cin  (bor_b),
    .sub  (1'b1),
    .y    (diff_b_unused),
    .cout (bor_b_nx)
  );

  // Range borrows advance with the limbs; flag registered in FIN, held to next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      bor_a       <= 1'b0;
      bor_b       <= 1'b0;
      range_err_r <= 1'b0;
    end else begin
      if (accept) begin
        bor_a       <= 1'b0;
        bor_b       <= 1'b0;
        range_err_r <= 1'b0;
      end
      if (step) begin
        bor_a <= bor_a_nx;
        bor_b <= bor_b_nx;
      end
      if (finish) begin
        range_err_r <= ~bor_a | ~bor_b;
      end
    end
  end

  assign bus.range_err = range_err_r;
`endif

  // Padding bits above N never reach the result; out_read does not affect sequencing.
  logic unused_bits;
  assign unused_bits = ^{s_sr[LW-1:N], t_sr[LW-1:N], bus.out_read};

endmodule

// File: tb/tb_modaddsub_serial.sv
// Scoreboard bench for modaddsub_serial: the driver pushes expected results
// (from a plain modular-arithmetic model) with their expected done cycle; a
// negedge monitor pops and checks whenever done is seen.
module tb_modaddsub_serial;
  import modaddsub_pkg::*;

  localparam logic [N-1:0] P =
    381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  typedef struct {
    logic [N-1:0] res;
    int unsigned  cyc;
    bit           chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];

  modaddsub_if bus ();

  modaddsub_serial dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [N-1:0] ref_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [N-1:0] m, input logic sub);
    logic [N+1:0] x;
    logic [N+1:0] r;
    if (sub) x = {2'b0, a} + {2'b0, m} - {2'b0, b};
    else     x = {2'b0, a} + {2'b0, b};
    r = x % {2'b0, m};
    return r[N-1:0];
  endfunction

  function automatic logic [N-1:0] rand_below(input logic [N-1:0] m);
    logic [447:0] x;
    logic [447:0] r;
    x = '0;
    for (int i = 0; i < 14; i++) x = {x[415:0], 32'($urandom)};
    r = x % {67'b0, m};
    return r[N-1:0];
  endfunction

  // Monitor: every done must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done cyc=%0d got done=1 want done=0", cyc);
      end else begin
        e = sb.pop_front();
        if (e.chk) begin
          vectors++;
          if (bus.result !== e.res) begin
            miscompares++;
            $display("FAIL result got=%h want=%h", bus.result, e.res);
          end
        end
        vectors++;
        if (cyc != e.cyc) begin
          miscompares++;
          $display("FAIL done_latency got cyc=%0d want cyc=%0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                       input logic [N-1:0] exp, input bit push, input bit chk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.subtract = sub;
    if (push) sb.push_back('{exp, cyc + L + 2, chk});
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_a     = rand_below(P);
    bus.in_b     = rand_below(P);
    bus.subtract = ~sub;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * L + 8; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout got done=0 want done=1 within %0d cycles", 4 * L + 8);
    end
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                        input logic [N-1:0] exp);
    issue(a, b, sub, exp, 1'b1, 1'b1);
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] a, b;
    logic         s;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.subtract = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_m     = P;
    bus.out_read = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.result !== '0) begin
      miscompares++;
      $display("FAIL reset_result got=%h want=0", bus.result);
    end
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done got=%b want=0", bus.done);
    end
    reset = 1'b0;

    // Directed corner cases.
    run_op(381'd1, 381'd1, 1'b0, 381'd2);
    run_op(P - 381'd1, 381'd1, 1'b0, '0);
    run_op(P - 381'd1, P - 381'd1, 1'b0, P - 381'd2);
    run_op(381'd1, 381'd2, 1'b1, P - 381'd1);
    run_op(381'd5, 381'd5, 1'b1, '0);

    // Second start mid-CALC is ignored.
    issue(381'd7, 381'd9, 1'b0, 381'd16, 1'b1, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in_a  = 381'd100;
    bus.in_b  = 381'd200;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Start in the same cycle as done is ignored.
    bus.start = 1'b1;
    bus.in_a  = 381'd3;
    bus.in_b  = 381'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (L + 4) @(negedge clk);

    // Reset mid-CALC aborts: no done, result cleared.
    issue(381'd11, 381'd12, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (bus.result !== '0) begin
      miscompares++;
      $display("FAIL abort_result got=%h want=0", bus.result);
    end
    repeat (L + 4) @(negedge clk);
    run_op(381'd20, 381'd22, 1'b1, P - 381'd2);

`ifdef MODADDSUB_RANGE_CHK_EN
    issue(P, '0, 1'b0, '0, 1'b1, 1'b0);
    wait_done();
    vectors++;
    if (bus.range_err !== 1'b1) begin
      miscompares++;
      $display("FAIL range_err_hi got=%b want=1", bus.range_err);
    end
    run_op(P - 381'd1, '0, 1'b0, P - 381'd1);
    vectors++;
    if (bus.range_err !== 1'b0) begin
      miscompares++;
      $display("FAIL range_err_lo got=%b want=0", bus.range_err);
    end
`endif

    // Randomised driver loop.
    for (int i = 0; i < 1000; i++) begin
      a = rand_below(P);
      b = rand_below(P);
      s = 1'($urandom_range(0, 1));
      run_op(a, b, s, ref_op(a, b, P, s));
    end

    repeat (L + 4) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL pending_results got=%0d want=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
